// File: rtl/bram_walker_if.sv
// Control and BRAM-port signal bundle for bram_walker.
// The walker uses the master modport; the control master and the memory share the slave side.
interface bram_walker_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [1:0]        mode;
    logic [DATA_W-1:0] operand;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, base_addr, length, mode, operand, mem_rdata,
        output busy, done, ovf, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output start, base_addr, length, mode, operand, mem_rdata,
        input  busy, done, ovf, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/bram_walker.sv
// Memory-walking FSMD: reads, transforms and writes back each word of a BRAM address window.
module bram_walker #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    bram_walker_if.master bus
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WAIT_W = 2;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_PROC, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] op_q, op_d, rdata_q, rdata_d, wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, we_q, we_d;

    // Shared datapath: one adder for add/saturating add, a single full-width multiplier.
    logic [DATA_W:0]   sum;
    logic [PROD_W-1:0] prod;
    logic [CNT_W-1:0]  cnt_inc;
    assign sum     = {1'b0, rdata_q} + {1'b0, op_q};
    assign prod    = PROD_W'(rdata_q) * PROD_W'(op_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        we_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d  = bus.length;
                    mode_d = bus.mode;
                    op_d   = bus.operand;
                    addr_d = bus.base_addr;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    if (bus.length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    rdata_d = bus.mem_rdata;
                    state_d = S_PROC;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_PROC: begin
                unique case (mode_q)
                    2'b00: begin
                        wdata_d = sum[DATA_W-1:0];
                        ovf_d   = ovf_q | sum[DATA_W];
                    end
                    2'b01: wdata_d = rdata_q ^ op_q;
                    2'b10: begin
                        wdata_d = prod[DATA_W-1:0];
                        ovf_d   = ovf_q | (|prod[PROD_W-1:DATA_W]);
                    end
                    default: begin
                        wdata_d = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
                        ovf_d   = ovf_q | sum[DATA_W];
                    end
                endcase
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d  = cnt_inc;
                addr_d = addr_q + ADDR_W'(1);
                if (cnt_inc == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_bram_walker.sv
// Bench for bram_walker: RD_LAT=1 and RD_LAT=2 instances run identical windows against
// behavioural BRAM models and a per-word arithmetic reference.
module tb_bram_walker;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic [1:0]  mode;
    logic [15:0] operand;

    always #5 clk = ~clk;

    bram_walker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    bram_walker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.start = start;  assign bus_b.start = start;
    assign bus_a.base_addr = base_addr;  assign bus_b.base_addr = base_addr;
    assign bus_a.length = length;  assign bus_b.length = length;
    assign bus_a.mode = mode;  assign bus_b.mode = mode;
    assign bus_a.operand = operand;  assign bus_b.operand = operand;

    bram_walker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a));
    bram_walker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b));

    // Synchronous single-port RAMs with 1- and 2-cycle read latency, plus write logs.
    logic [15:0] mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    logic [15:0] rd_a, rd_b1, rd_b2;
    int unsigned wq_a[$], wq_b[$];
    logic        we_prev_a = 1'b0, we_prev_b = 1'b0;
    int unsigned dbl_a = 0, dbl_b = 0;

    always @(posedge clk) begin
        if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            wq_a.push_back(int'(bus_a.mem_addr));
        end
        if (bus_b.mem_we) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
            wq_b.push_back(int'(bus_b.mem_addr));
        end
        rd_a  <= mem_a[bus_a.mem_addr];
        rd_b1 <= mem_b[bus_b.mem_addr];
        rd_b2 <= rd_b1;
        if (bus_a.mem_we && we_prev_a) dbl_a <= dbl_a + 1;
        if (bus_b.mem_we && we_prev_b) dbl_b <= dbl_b + 1;
        we_prev_a <= bus_a.mem_we;
        we_prev_b <= bus_b.mem_we;
    end
    assign bus_a.mem_rdata = rd_a;
    assign bus_b.mem_rdata = rd_b2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference operation on one word: returns {overflow, result}.
    function automatic logic [16:0] op_fn(input logic [15:0] d, input int unsigned md,
                                          input logic [15:0] op);
        longint unsigned full;
        logic [15:0]     res;
        logic            o;
        full = 0;
        case (md)
            0: full = 64'(d) + 64'(op);
            2: full = 64'(d) * 64'(op);
            3: full = 64'(d) + 64'(op);
            default: full = 64'(d ^ op);
        endcase
        o   = (md != 1) && (full > 65535);
        res = (md == 3 && o) ? 16'hFFFF : 16'(full % 65536);
        return {o, res};
    endfunction

    logic [15:0] exp_a [DEPTH];
    logic [15:0] exp_b [DEPTH];

    task automatic run(input int unsigned len, input int unsigned base, input int unsigned md,
                       input int unsigned op, input bit perturb, input bit rst_b_mid);
        logic [16:0] r;
        logic        exp_ovf_a, exp_ovf_b, ovf_done_a, ovf_done_b;
        int unsigned lat_a, lat_b, we_b, rst_t, ord_err, nbad, a;
        @(negedge clk);
        exp_ovf_a = 1'b0; exp_ovf_b = 1'b0; ovf_done_a = 1'b0; ovf_done_b = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_a[i] = mem_a[i];
            exp_b[i] = mem_b[i];
        end
        for (int unsigned k = 0; k < len; k++) begin
            a = (base + k) % DEPTH;
            r = op_fn(exp_a[a], md, 16'(op));
            exp_a[a] = r[15:0];
            exp_ovf_a |= r[16];
            if (!rst_b_mid || k == 0) begin
                r = op_fn(exp_b[a], md, 16'(op));
                exp_b[a] = r[15:0];
                exp_ovf_b |= r[16];
            end
        end
        wq_a.delete(); wq_b.delete();
        base_addr = 8'(base); length = 9'(len); mode = 2'(md); operand = 16'(op);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 8'($urandom); length = 9'($urandom); mode = 2'($urandom);
        operand = 16'($urandom);
        lat_a = 0; lat_b = 0; we_b = 0; rst_t = 0;
        if (len > 0) begin
            check("busy_a_start", 32'(bus_a.busy), 1);
            check("busy_b_start", 32'(bus_b.busy), 1);
        end
        for (int unsigned t = 1; t <= 4000; t++) begin
            if (perturb && t == 3) begin
                start = 1'b1;
                operand = 16'($urandom);
            end
            if (perturb && t == 4) start = 1'b0;
            if (bus_a.done && lat_a == 0) begin lat_a = t; ovf_done_a = bus_a.ovf; end
            if (bus_b.done && lat_b == 0) begin lat_b = t; ovf_done_b = bus_b.ovf; end
            if (rst_b_mid) begin
                if (bus_b.mem_we && rst_t == 0) begin
                    we_b++;
                    if (we_b == 2) begin
                        rst_b = 1'b1;
                        rst_t = t;
                        #1;
                        check("rst_we", 32'(bus_b.mem_we), 0);
                        check("rst_flags", {29'd0, bus_b.busy, bus_b.done, bus_b.ovf}, 0);
                        check("rst_addr", 32'(bus_b.mem_addr), 0);
                        check("rst_wdata", 32'(bus_b.mem_wdata), 0);
                    end
                end else if (rst_t != 0 && t == rst_t + 3) begin
                    rst_b = 1'b0;
                end
            end
            if (lat_a != 0 && (rst_b_mid ? (rst_t != 0 && !rst_b) : (lat_b != 0))) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("latency_a", lat_a, len * 4 + 1);
        check("ovf_at_done_a", 32'(ovf_done_a), 32'(exp_ovf_a));
        check("ovf_after_a", 32'(bus_a.ovf), 32'(exp_ovf_a));
        check("idle_a", {30'd0, bus_a.busy, bus_a.done}, 0);
        check("wr_count_a", wq_a.size(), len);
        if (rst_b_mid) begin
            check("no_done_b", lat_b, 0);
            check("wr_count_b", wq_b.size(), 1);
            check("ovf_after_b", 32'(bus_b.ovf), 0);
        end else begin
            check("latency_b", lat_b, len * 5 + 1);
            check("ovf_at_done_b", 32'(ovf_done_b), 32'(exp_ovf_b));
            check("ovf_after_b", 32'(bus_b.ovf), 32'(exp_ovf_b));
            check("wr_count_b", wq_b.size(), len);
        end
        check("idle_b", {30'd0, bus_b.busy, bus_b.done}, 0);
        ord_err = 0;
        foreach (wq_a[k]) if (wq_a[k] != (base + unsigned'(k)) % DEPTH) ord_err++;
        foreach (wq_b[k]) if (wq_b[k] != (base + unsigned'(k)) % DEPTH) ord_err++;
        check("write_order", ord_err, 0);
        nbad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem_a[i] !== exp_a[i]) nbad++;
        check("mem_a_contents", nbad, 0);
        nbad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem_b[i] !== exp_b[i]) nbad++;
        check("mem_b_contents", nbad, 0);
    endtask

    initial begin
        logic [15:0] v;
        int unsigned len;
        rst_a = 1'b1; rst_b = 1'b1;
        start = 1'b0; base_addr = '0; length = '0; mode = '0; operand = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_a[i] <= 16'(i);
            mem_b[i] <= 16'(i);
        end
        repeat (3) @(negedge clk);
        check("reset_flags_a", {28'd0, bus_a.busy, bus_a.done, bus_a.ovf, bus_a.mem_we}, 0);
        check("reset_flags_b", {28'd0, bus_b.busy, bus_b.done, bus_b.ovf, bus_b.mem_we}, 0);
        check("reset_addr_a", 32'(bus_a.mem_addr), 0);
        check("reset_wdata_a", 32'(bus_a.mem_wdata), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        run(4, 0, 0, 1, 0, 0);
        check("inc_mem0", 32'(mem_a[0]), 1);
        check("inc_mem3", 32'(mem_a[3]), 4);
        check("inc_mem4_untouched", 32'(mem_a[4]), 4);

        run(4, 'hFE, 1, 'h00FF, 0, 0);
        check("wrap_first_addr", wq_a[0], 'hFE);
        check("wrap_third_addr", wq_a[2], 'h00);
        check("wrap_memFE", 32'(mem_a[254]), 'h0001);

        mem_a[0] <= 16'h0020; mem_b[0] <= 16'h0020;
        run(1, 0, 3, 'hFFF0, 0, 0);
        check("sat_mem0", 32'(mem_a[0]), 'hFFFF);
        repeat (5) @(negedge clk);
        check("sat_ovf_sticky", 32'(bus_a.ovf), 1);

        mem_a[0] <= 16'h6000; mem_b[0] <= 16'h6000;
        run(1, 0, 2, 3, 0, 0);
        check("mul_mem0", 32'(mem_a[0]), 'h2000);
        check("mul_ovf", 32'(bus_a.ovf), 1);
        mem_a[0] <= 16'd5; mem_b[0] <= 16'd5;
        run(1, 0, 2, 3, 0, 0);
        check("mul2_mem0", 32'(mem_b[0]), 15);
        check("mul2_ovf_cleared", 32'(bus_b.ovf), 0);

        run(0, $urandom_range(0, 255), 0, $urandom, 0, 0);
        run(6, 250, 0, $urandom, 1, 0);
        run(3, 40, 1, $urandom, 0, 1);

        for (int i = 0; i < int'(DEPTH); i++) begin
            v = 16'($urandom);
            mem_a[i] <= v;
            mem_b[i] <= v;
        end
        run(256, $urandom_range(0, 255), $urandom_range(0, 3), $urandom, 1, 0);
        repeat (14) begin
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
            run(len, $urandom_range(0, 255), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom, 1, 0);
        end

        check("we_single_cycle_a", dbl_a, 0);
        check("we_single_cycle_b", dbl_b, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_walker.md
Name: bram_walker

Overview:
- Parametrised memory-walking FSMD. Sweeps a contiguous address window of a synchronous single-port block RAM.
- For each word it performs read → wait → process → write-back, applying a runtime-selected operation.
- It is the general successor of the fixed 256×16 increment walker. Width, depth, read latency, base address, length and operation are all configurable.
- Sits between a control master (start/done) and one BRAM port.

Parameters:
- DATA_W, 16, data word width in bits
- ADDR_W, 8, memory address width; depth = 2^ADDR_W
- RD_LAT, 1, BRAM read latency in cycles; legal values are 1 and 2

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- base_addr  in  ADDR_W  first address of the window
- length  in  ADDR_W+1  number of words to process, 0 to 2^ADDR_W
- mode  in  2  operation select: 00 add, 01 xor, 10 multiply, 11 saturating add
- operand  in  DATA_W  second operand for the operation
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- ovf  out  1  sticky overflow flag for the current run
- mem_addr  out  ADDR_W  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after the address is sampled

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - On reset, all outputs go to 0 immediately: busy, done, ovf, mem_addr, mem_we, mem_wdata. The state returns to IDLE.
  - Reset mid-run abandons the run. No further write occurs; a write that was in progress is dropped when mem_we drops.
- Output timing: all outputs are registered (Moore). There is no combinational path from any input to any output.
- States: IDLE, READ, WAIT, PROC, WRITE, DONE.
- IDLE:
  - On start=1, latch base_addr, length, mode and operand into internal registers; later input changes have no effect on the run.
  - Clear ovf, set mem_addr=base_addr, set element counter=0, go to READ. If length==0, go to DONE instead.
- READ: 1 cycle. mem_we=0 and mem_addr holds the current address. Go to WAIT.
- WAIT:
  - Lasts exactly RD_LAT cycles.
  - On the clock edge ending the last WAIT cycle, mem_rdata is captured into the rdata register.
  - Then go to PROC.
- PROC: 1 cycle. Compute the result from the captured data d and the latched operand into the result register, which drives mem_wdata:
  - 00: result = (d + operand) mod 2^DATA_W. Carry-out sets ovf.
  - 01: result = d xor operand. ovf is unaffected.
  - 10: result = low DATA_W bits of d × operand. The full 2·DATA_W-bit product comes from one multiplier instance; it is the only multiplier in the block. Any nonzero high half sets ovf.
  - 11: result = d + operand, clamped to 2^DATA_W−1 on carry. Clamping sets ovf.
  - All operations are unsigned. ovf stays set until the next accepted start.
- WRITE:
  - Exactly 1 cycle with mem_we=1; mem_addr and mem_wdata stay stable for that cycle.
  - On exit, mem_we=0, element counter +1, mem_addr = (mem_addr + 1) mod 2^ADDR_W.
  - If counter+1 == latched length, go to DONE; otherwise go to READ.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Throughput: RD_LAT+3 cycles per word. Total cycles from start acceptance to the done pulse = length·(RD_LAT+3) + 1.
- Address wrap: a window crossing the top address wraps to 0. length = 2^ADDR_W touches every address exactly once.
- start while busy is ignored and has no side effects. start held high through DONE launches a new run from IDLE on the following cycle.
- Each address is written exactly once per run, in ascending (modulo) order. No address outside the window is ever written.

Test Plan:
- RD_LAT=1; memory preloaded with mem[i]=i. start with base=0, length=4, mode=00, operand=1 → writes mem[0..3]=1,2,3,4; mem_we high for one cycle per word; done pulses 17 cycles after start; ovf=0; mem[4] unchanged.
- base=8'hFE, length=4, mode=01, operand=16'h00FF → writes occur at addresses FE, FF, 00, 01 in that order; each written value = preload xor 00FF.
- mode=11, operand=16'hFFF0, mem[0]=16'h0020, length=1 → mem[0]=16'hFFFF; ovf=1 and stays 1 after done until the next start.
- mode=10, operand=3, mem[0]=16'h6000 → mem[0]=16'h2000, ovf=1. A second run with mem[0]=5 → mem[0]=15, ovf cleared to 0.
- length=0 → done pulses 1 cycle after start; mem_we never asserts. A start pulse mid-run is ignored, and changing operand mid-run does not alter the results.
- RD_LAT=2, length=3 → 5 cycles per word. Assert reset during WRITE of word 1 → mem_we drops immediately, word 2 is never written, all outputs are 0.
